// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-master flash Wishbone arbiter.
// The optional transaction timeout is enabled with FLASH_ARB_TIMEOUT_EN.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        REJ  = 2'd3
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEF = 32;
    localparam int ARB_CNT_W       = $clog2(ARB_TIMEOUT_DEF);

    // One-hot grant as seen by the masters; IDLE and REJ grant nobody.
    function automatic logic [1:0] arb_gnt_onehot(input arb_state_t s);
        case (s)
            GNT0:    return 2'b01;
            GNT1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/flash_arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the master that was
// not served last wins; o_pick is the winning master index.
module flash_arb_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_pick,
    output logic       o_valid
);

    assign o_valid = |i_req;
    assign o_pick  = (&i_req) ? ~i_last : i_req[1];

endmodule

// File: rtl/flash_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the read-only flash slave.
// Optional abort of stalled transfers is built when FLASH_ARB_TIMEOUT_EN is defined.
module flash_wb_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [3:0]        s_sel_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o,
    output arb_state_t        dbg_state_o
);

    // Handshake: a master requests with cyc&stb held until it sees ack or err;
    // the slave side follows the granted master's cyc/stb, and ack/data are
    // passed back only to the granted master in the same cycle.

    arb_state_t r_state;
    logic       r_last;

    logic [1:0] w_req;
    logic       w_pick;
    logic       w_valid;
    logic       w_pick_we;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_cur_cyc;
    logic       w_tout;
    logic       w_unused;

    assign w_req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign w_pick_we = w_pick ? m1_we_i : m0_we_i;
    assign w_gnt0    = (r_state == GNT0);
    assign w_gnt1    = (r_state == GNT1);
    assign w_cur_cyc = w_gnt1 ? m1_cyc_i : m0_cyc_i;

    // Write data never reaches the read-only slave.
    assign w_unused  = ^{m0_dat_i, m1_dat_i, 32'(TIMEOUT)};

    flash_arb_rr_pick u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_valid (w_valid)
    );

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cnt <= '0;
        end else if (!(w_gnt0 || w_gnt1)) begin
            r_cnt <= '0;
        end else if (!s_ack_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A late ack on the expiry cycle still completes the transfer normally.
    assign w_tout = (w_gnt0 || w_gnt1) && (r_cnt == CNT_W'(TIMEOUT - 1)) && !s_ack_i;
`else
    assign w_tout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_last  <= w_pick;
                        r_state <= w_pick_we ? REJ : (w_pick ? GNT1 : GNT0);
                    end
                end
                GNT0, GNT1: begin
                    // Always pass through IDLE so the slave sees cyc low between transfers.
                    if (s_ack_i || !w_cur_cyc || w_tout) begin
                        r_state <= IDLE;
                    end
                end
                REJ:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_cyc_o = ((w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i)) & ~w_tout;
    assign s_stb_o = ((w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i)) & ~w_tout;
    assign s_we_o  = 1'b0;
    assign s_adr_o = w_gnt1 ? m1_adr_i : (w_gnt0 ? m0_adr_i : '0);
    assign s_sel_o = w_gnt1 ? m1_sel_i : (w_gnt0 ? m0_sel_i : 4'h0);

    assign m0_dat_o = w_gnt0 ? s_dat_i : '0;
    assign m1_dat_o = w_gnt1 ? s_dat_i : '0;
    assign m0_ack_o = w_gnt0 & s_ack_i;
    assign m1_ack_o = w_gnt1 & s_ack_i;

    // In REJ, r_last already names the rejected master.
    assign m0_err_o = ((r_state == REJ) & ~r_last) | (w_gnt0 & w_tout);
    assign m1_err_o = ((r_state == REJ) &  r_last) | (w_gnt1 & w_tout);

    assign gnt_o       = arb_gnt_onehot(r_state);
    assign dbg_state_o = r_state;

endmodule
